mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_tag_table.sv | 47 ++++
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: bus commands, tags and
// the per-tag ownership entry.
package mem_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef logic [TAG_W-1:0] MEM_TAG;

    typedef struct packed {
        logic valid;
        logic squash;
        logic owner_d;
    } tag_entry_t;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load ownership table indexed by memory tag; supports
// write, lookup-and-clear and squash-all-I-owned in the same cycle.
module mem_tag_table
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_MEM_TAGS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_owner_d,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic             squash_i,
    output logic             hit,
    output logic             hit_owner_d
);

    tag_entry_t entries [NUM_MEM_TAGS];
    tag_entry_t cur;
    logic       returning;

    always_comb begin
        cur         = entries[lookup_tag];
        returning   = (lookup_tag != '0) && cur.valid;
        hit         = returning && !cur.squash;
        hit_owner_d = cur.owner_d;
    end

    // A new allocation is applied last so it survives a same-tag return.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MEM_TAGS; i++)
                entries[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MEM_TAGS; i++)
                if (squash_i && entries[i].valid && !entries[i].owner_d)
                    entries[i].squash <= 1'b1;
            if (returning)
                entries[lookup_tag] <= '0;
            if (wr_en)
                entries[wr_tag] <= '{valid: 1'b1, squash: 1'b0,
                                     owner_d: wr_owner_d};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-side and D-side requests onto one memory port, with
// starvation protection for fetch and tag-based return routing.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_MEM_TAGS = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            branch_flush_en,
    input  logic            icache_req_valid,
    input  logic [XLEN-1:0] icache_req_addr,
    output logic            icache_req_ack,
    output logic            icache_resp_valid,
    output logic [63:0]     icache_resp_data,
    input  logic            dcache_req_valid,
    input  logic [1:0]      dcache_req_cmd,
    input  logic [XLEN-1:0] dcache_req_addr,
    input  logic [63:0]     dcache_req_data,
    output logic            dcache_req_ack,
    output logic            dcache_resp_valid,
    output logic [63:0]     dcache_resp_data,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [3:0]      mem2proc_tag,
    input  logic [63:0]     mem2proc_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             grant_i;
    logic             grant_d;
    logic             accept;
    logic             alloc;
    logic             hit;
    logic             hit_owner_d;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign accept  = (mem2proc_response != '0);

    always_comb begin
        grant_i = !reset && icache_req_valid && !branch_flush_en
                  && (!dcache_req_valid || starved);
        grant_d = !reset && dcache_req_valid && !grant_i;
        alloc   = accept && (grant_i
                  || (grant_d && dcache_req_cmd == BUS_LOAD));
    end

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_i) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = icache_req_addr;
        end else if (grant_d) begin
            proc2mem_command = dcache_req_cmd;
            proc2mem_addr    = dcache_req_addr;
            proc2mem_data    = dcache_req_data;
        end
    end

    assign icache_req_ack = grant_i && accept;
    assign dcache_req_ack = grant_d && accept;

    always_comb begin
        icache_resp_valid = !reset && hit && !hit_owner_d;
        dcache_resp_valid = !reset && hit && hit_owner_d;
        icache_resp_data  = icache_resp_valid ? mem2proc_data : '0;
        dcache_resp_data  = dcache_resp_valid ? mem2proc_data : '0;
    end

    // Counts D wins against a waiting fetch; rejected grants do not count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (icache_req_ack)
            starve_cnt <= '0;
        else if (dcache_req_ack && icache_req_valid && !starved)
            starve_cnt <= starve_cnt + 1'b1;
    end

    mem_tag_table #(
        .NUM_MEM_TAGS(NUM_MEM_TAGS)
    ) u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (alloc),
        .wr_tag      (mem2proc_response),
        .wr_owner_d  (grant_d),
        .lookup_tag  (mem2proc_tag),
        .squash_i    (branch_flush_en),
        .hit         (hit),
        .hit_owner_d (hit_owner_d)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a tag-table
// reference model built from the arbitration and return rules.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            branch_flush_en;
    logic            icache_req_valid;
    logic [XLEN-1:0] icache_req_addr;
    logic            icache_req_ack;
    logic            icache_resp_valid;
    logic [63:0]     icache_resp_data;
    logic            dcache_req_valid;
    logic [1:0]      dcache_req_cmd;
    logic [XLEN-1:0] dcache_req_addr;
    logic [63:0]     dcache_req_data;
    logic            dcache_req_ack;
    logic            dcache_resp_valid;
    logic [63:0]     dcache_resp_data;
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [3:0]      mem2proc_response;
    logic [3:0]      mem2proc_tag;
    logic [63:0]     mem2proc_data;

    int vectors = 0;
    int miscompares = 0;

    // reference state: who owns each outstanding tag
    bit m_valid [16];
    bit m_squash [16];
    bit m_owner_d [16];
    int m_starve;
    bit m_gi, m_gd, m_acc;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .branch_flush_en   (branch_flush_en),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_ack    (icache_req_ack),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_data  (icache_resp_data),
        .dcache_req_valid  (dcache_req_valid),
        .dcache_req_cmd    (dcache_req_cmd),
        .dcache_req_addr   (dcache_req_addr),
        .dcache_req_data   (dcache_req_data),
        .dcache_req_ack    (dcache_req_ack),
        .dcache_resp_valid (dcache_resp_valid),
        .dcache_resp_data  (dcache_resp_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_tag      (mem2proc_tag),
        .mem2proc_data     (mem2proc_data)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0;
        branch_flush_en = 0;
        icache_req_valid = 0;
        icache_req_addr = '0;
        dcache_req_valid = 0;
        dcache_req_cmd = BUS_NONE;
        dcache_req_addr = '0;
        dcache_req_data = '0;
        mem2proc_response = 0;
        mem2proc_tag = 0;
        mem2proc_data = '0;
    endtask

    task automatic check_model();
        logic [1:0]      e_cmd;
        logic [XLEN-1:0] e_addr;
        logic [63:0]     e_data;
        bit              ret, e_iv, e_dv;
        #1;
        m_gi = 0;
        m_gd = 0;
        if (!reset) begin
            if (icache_req_valid && !branch_flush_en &&
                (!dcache_req_valid || m_starve == LIMIT))
                m_gi = 1;
            else if (dcache_req_valid)
                m_gd = 1;
        end
        m_acc = (mem2proc_response != 0);
        e_cmd = m_gi ? BUS_LOAD : (m_gd ? dcache_req_cmd : BUS_NONE);
        e_addr = m_gi ? icache_req_addr : (m_gd ? dcache_req_addr : '0);
        e_data = m_gd ? dcache_req_data : '0;
        ret = !reset && mem2proc_tag != 0 && m_valid[mem2proc_tag]
              && !m_squash[mem2proc_tag];
        e_iv = ret && !m_owner_d[mem2proc_tag];
        e_dv = ret && m_owner_d[mem2proc_tag];
        chk("icache_req_ack", 64'(icache_req_ack), 64'(m_gi && m_acc));
        chk("dcache_req_ack", 64'(dcache_req_ack), 64'(m_gd && m_acc));
        chk("proc2mem_command", 64'(proc2mem_command), 64'(e_cmd));
        chk("proc2mem_addr", 64'(proc2mem_addr), 64'(e_addr));
        if (!m_gi) chk("proc2mem_data", proc2mem_data, e_data);
        chk("icache_resp_valid", 64'(icache_resp_valid), 64'(e_iv));
        chk("dcache_resp_valid", 64'(dcache_resp_valid), 64'(e_dv));
        if (e_iv) chk("icache_resp_data", icache_resp_data, mem2proc_data);
        if (e_dv) chk("dcache_resp_data", dcache_resp_data, mem2proc_data);
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0;
                m_squash[i] = 0;
                m_owner_d[i] = 0;
            end
            m_starve = 0;
        end else begin
            if (branch_flush_en)
                for (int i = 0; i < 16; i++)
                    if (m_valid[i] && !m_owner_d[i]) m_squash[i] = 1;
            if (mem2proc_tag != 0 && m_valid[mem2proc_tag]) begin
                m_valid[mem2proc_tag] = 0;
                m_squash[mem2proc_tag] = 0;
            end
            if (m_acc && (m_gi || (m_gd && dcache_req_cmd == BUS_LOAD))) begin
                m_valid[mem2proc_response] = 1;
                m_squash[mem2proc_response] = 0;
                m_owner_d[mem2proc_response] = m_gd;
            end
            if (m_acc && m_gi)
                m_starve = 0;
            else if (m_acc && m_gd && icache_req_valid && m_starve < LIMIT)
                m_starve++;
        end
        @(negedge clock);
    endtask

    task automatic step();
        check_model();
        tick();
    endtask

    initial begin
        idle();
        reset = 1;
        m_starve = 0;
        @(negedge clock);
        check_model();
        chk("reset_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("reset_dack", 64'(dcache_req_ack), 64'd0);
        tick();
        step();
        idle();

        // D priority until the fetch side has waited LIMIT grants
        icache_req_valid = 1;
        icache_req_addr = 32'h0000_1000;
        dcache_req_valid = 1;
        dcache_req_cmd = BUS_STORE;
        dcache_req_addr = 32'h0000_2000;
        dcache_req_data = 64'h1111_2222_3333_4444;
        mem2proc_response = 3;
        for (int k = 0; k < 4; k++) begin
            check_model();
            chk("starve_d_ack", 64'(dcache_req_ack), 64'd1);
            chk("starve_i_wait", 64'(icache_req_ack), 64'd0);
            tick();
        end
        check_model();
        chk("starve_i_ack", 64'(icache_req_ack), 64'd1);
        chk("starve_d_wait", 64'(dcache_req_ack), 64'd0);
        tick();
        idle();

        // I load with tag 5 returns to fetch
        icache_req_valid = 1;
        icache_req_addr = 32'h0000_0040;
        mem2proc_response = 5;
        step();
        idle();
        mem2proc_tag = 5;
        mem2proc_data = 64'hDEADBEEF_00000001;
        check_model();
        chk("i_return_valid", 64'(icache_resp_valid), 64'd1);
        chk("i_return_data", icache_resp_data, 64'hDEADBEEF_00000001);
        tick();
        check_model();
        chk("i_return_cleared", 64'(icache_resp_valid), 64'd0);
        tick();
        idle();

        // flush squashes outstanding tag 7
        icache_req_valid = 1;
        mem2proc_response = 7;
        step();
        idle();
        branch_flush_en = 1;
        icache_req_valid = 1;
        mem2proc_response = 8;
        check_model();
        chk("flush_blocks_i", 64'(icache_req_ack), 64'd0);
        tick();
        idle();
        mem2proc_tag = 7;
        mem2proc_data = 64'h7777;
        check_model();
        chk("squashed_return", 64'(icache_resp_valid), 64'd0);
        tick();
        idle();

        // stores are not tracked
        dcache_req_valid = 1;
        dcache_req_cmd = BUS_STORE;
        dcache_req_addr = 32'h0000_0100;
        dcache_req_data = 64'hABCD;
        mem2proc_response = 2;
        step();
        idle();
        mem2proc_tag = 2;
        check_model();
        chk("store_no_dresp", 64'(dcache_resp_valid), 64'd0);
        chk("store_no_iresp", 64'(icache_resp_valid), 64'd0);
        tick();
        idle();

        // rejected responses retry until accepted
        dcache_req_valid = 1;
        dcache_req_cmd = BUS_LOAD;
        dcache_req_addr = 32'h0000_0200;
        for (int k = 0; k < 3; k++) begin
            check_model();
            chk("reject_no_ack", 64'(dcache_req_ack), 64'd0);
            tick();
        end
        mem2proc_response = 9;
        check_model();
        chk("accept_ack", 64'(dcache_req_ack), 64'd1);
        tick();
        idle();
        mem2proc_tag = 9;
        mem2proc_data = 64'h9999;
        check_model();
        chk("d_return_valid", 64'(dcache_resp_valid), 64'd1);
        tick();
        idle();

        // same-tag return and reallocation
        dcache_req_valid = 1;
        dcache_req_cmd = BUS_LOAD;
        mem2proc_response = 4;
        step();
        idle();
        icache_req_valid = 1;
        mem2proc_response = 4;
        mem2proc_tag = 4;
        mem2proc_data = 64'h4444_0000;
        check_model();
        chk("realloc_old_d", 64'(dcache_resp_valid), 64'd1);
        chk("realloc_i_ack", 64'(icache_req_ack), 64'd1);
        tick();
        idle();
        mem2proc_tag = 4;
        mem2proc_data = 64'h4444_1111;
        check_model();
        chk("realloc_new_i", 64'(icache_resp_valid), 64'd1);
        tick();
        idle();

        // reset drops outstanding ownership
        dcache_req_valid = 1;
        dcache_req_cmd = BUS_LOAD;
        mem2proc_response = 6;
        step();
        idle();
        reset = 1;
        step();
        idle();
        mem2proc_tag = 6;
        check_model();
        chk("post_reset_drop", 64'(dcache_resp_valid), 64'd0);
        tick();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            reset = ($urandom_range(0, 99) == 0);
            branch_flush_en = ($urandom_range(0, 9) == 0);
            icache_req_valid = $urandom_range(0, 1);
            icache_req_addr = $urandom & 32'hFFFF_FFF8;
            dcache_req_valid = $urandom_range(0, 1);
            dcache_req_cmd = $urandom_range(1, 2);
            dcache_req_addr = $urandom & 32'hFFFF_FFF8;
            dcache_req_data = {$urandom, $urandom};
            mem2proc_response = ($urandom_range(0, 9) < 3) ? 4'd0
                                : 4'($urandom_range(1, 15));
            mem2proc_tag = $urandom_range(0, 1) ? 4'($urandom_range(1, 15))
                           : 4'd0;
            mem2proc_data = {$urandom, $urandom};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
